// File: rtl/vga_sprite_renderer.sv
// Composites one SPR_W x SPR_H sprite from an external synchronous ROM over a
// solid background, keeping colour and sync aligned two cycles behind the scan.
module vga_sprite_renderer #(
    parameter int          COORD_W  = 10,
    parameter int          SPR_W    = 32,
    parameter int          SPR_H    = 32,
    parameter int          H_OFFSET = 142,
    parameter int          V_OFFSET = 32,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    input  logic               VALID,
    input  logic               H_SYNC_IN,
    input  logic               V_SYNC_IN,
    input  logic [COORD_W-1:0] POS_X,
    input  logic [COORD_W-1:0] POS_Y,
    input  logic               POS_REQ,
    output logic               POS_ACK,
    output logic [9:0]         ROM_ADDR,
    input  logic [12:0]        ROM_DATA,
    output logic [3:0]         R,
    output logic [3:0]         G,
    output logic [3:0]         B,
    output logic               H_SYNC,
    output logic               V_SYNC,
    output logic               FRAME_TICK
);

    localparam int CW     = COORD_W + 1;
    localparam int ADDR_W = 10;
    localparam int XB     = $clog2(SPR_W);
    localparam int YB     = ADDR_W - XB;

    logic [COORD_W-1:0] sx, sy;
    logic [CW-1:0]      px, py, sx_ext, sy_ext, dx, dy;
    logic               hit, at_commit;

    // Extra top bit keeps left/top-of-screen underflow and far-right positions
    // from aliasing into the sprite window.
    assign px        = {1'b0, X} - CW'(H_OFFSET);
    assign py        = {1'b0, Y} - CW'(V_OFFSET);
    assign sx_ext    = {1'b0, sx};
    assign sy_ext    = {1'b0, sy};
    assign dx        = px - sx_ext;
    assign dy        = py - sy_ext;
    assign hit       = VALID && (px >= sx_ext) && (dx < CW'(SPR_W))
                             && (py >= sy_ext) && (dy < CW'(SPR_H));
    assign at_commit = (X == '0) && (Y == '0);

    // POS_REQ is a level request with POS_X/POS_Y held stable alongside it.
    // It is looked at only in the commit cycle (X==0, Y==0): there the position
    // is latched and POS_ACK pulses for one cycle; otherwise it is ignored, and
    // a request still high at the next commit is taken (and acked) again.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sx         <= COORD_W'(640);
            sy         <= COORD_W'(480);
            POS_ACK    <= 1'b0;
            FRAME_TICK <= 1'b0;
        end else begin
            FRAME_TICK <= at_commit;
            POS_ACK    <= at_commit && POS_REQ;
            if (at_commit && POS_REQ) begin
                sx <= POS_X;
                sy <= POS_Y;
            end
        end
    end

    // Stage 1 issues the ROM address; stage 2 waits out the ROM read so the
    // hit/valid/sync copies line up with ROM_DATA at the output register.
    logic s1_hit, s1_valid, s1_hs, s1_vs;
    logic s2_hit, s2_valid, s2_hs, s2_vs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ROM_ADDR <= '0;
            s1_hit   <= 1'b0;
            s1_valid <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s2_hit   <= 1'b0;
            s2_valid <= 1'b0;
            s2_hs    <= 1'b1;
            s2_vs    <= 1'b1;
        end else begin
            if (hit) begin
                ROM_ADDR <= {dy[YB-1:0], dx[XB-1:0]};
            end
            s1_hit   <= hit;
            s1_valid <= VALID;
            s1_hs    <= H_SYNC_IN;
            s1_vs    <= V_SYNC_IN;
            s2_hit   <= s1_hit;
            s2_valid <= s1_valid;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
        end
    end

    logic [11:0] rgb_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rgb_q  <= '0;
            H_SYNC <= 1'b1;
            V_SYNC <= 1'b1;
        end else begin
            if (!s2_valid) begin
                rgb_q <= '0;
            end else if (s2_hit && ROM_DATA[12]) begin
                rgb_q <= ROM_DATA[11:0];
            end else begin
                rgb_q <= BG_COLOR;
            end
            H_SYNC <= s2_hs;
            V_SYNC <= s2_vs;
        end
    end

    assign R = rgb_q[11:8];
    assign G = rgb_q[7:4];
    assign B = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Randomised scan-coordinate stimulus against a rule-level sprite model, with
// expected pixels/events queued per cycle and checked by a separate monitor.
module tb_vga_sprite_renderer;

  localparam logic [11:0] BG = 12'h00F;
  localparam int H_OFF = 142;
  localparam int V_OFF = 32;
  localparam int PW = 32 + 14;  // {due, rgb, hs, vs}
  localparam int EW = 32 + 12;  // {due, addr, tick, ack}

  logic        CLK, RST;
  logic [9:0]  X, Y, POS_X, POS_Y, ROM_ADDR;
  logic        VALID, H_SYNC_IN, V_SYNC_IN, POS_REQ, POS_ACK;
  logic [12:0] ROM_DATA;
  logic [3:0]  R, G, B;
  logic        H_SYNC, V_SYNC, FRAME_TICK;

  vga_sprite_renderer #(.BG_COLOR(BG)) dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y), .VALID(VALID),
    .H_SYNC_IN(H_SYNC_IN), .V_SYNC_IN(V_SYNC_IN),
    .POS_X(POS_X), .POS_Y(POS_Y), .POS_REQ(POS_REQ), .POS_ACK(POS_ACK),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .R(R), .G(G), .B(B), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
    .FRAME_TICK(FRAME_TICK)
  );

  // ---------------- clock / reset ----------------
  int unsigned cyc = 0;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- external ROM ----------------
  logic [12:0] rom [1024];
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  // ---------------- reference model state ----------------
  logic [PW-1:0] exp_q[$];
  logic [EW-1:0] evt_q[$];
  int   m_sx = 640, m_sy = 480;
  logic [9:0] m_addr = '0;
  bit   req_v = 0;
  int   pos_x_v = 0, pos_y_v = 0;
  int   checks = 0, failures = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input int x, input int y, input bit rst);
    logic [31:0] k;
    logic [PW-1:0] e;
    bit valid, hs, vs, hit, commit, ack;
    int px, py, a;
    logic [11:0] rgb;
    @(negedge CLK);
    k = cyc + 1;
    valid = (x >= H_OFF) && (x < H_OFF + 640) && (y >= V_OFF) && (y < V_OFF + 480);
    hs = (x >= 96);
    vs = (y >= 2);
    if ($urandom_range(0, 15) == 0) hs = !hs;
    if ($urandom_range(0, 15) == 0) vs = !vs;
    RST = rst; X = 10'(x); Y = 10'(y); VALID = valid;
    H_SYNC_IN = hs; V_SYNC_IN = vs;
    POS_REQ = req_v; POS_X = 10'(pos_x_v); POS_Y = 10'(pos_y_v);
    if (rst) begin
      // A reset edge blanks every output still in flight.
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        if (e[PW-1 -: 32] >= k) exp_q[i] = {e[PW-1 -: 32], 12'h000, 2'b11};
      end
      exp_q.push_back({k + 32'd2, 12'h000, 2'b11});
      evt_q.push_back({k, 10'd0, 1'b0, 1'b0});
      m_sx = 640; m_sy = 480; m_addr = '0;
    end else begin
      px = x - H_OFF;
      py = y - V_OFF;
      hit = valid && (px >= m_sx) && (px - m_sx < 32) && (py >= m_sy) && (py - m_sy < 32);
      rgb = '0;
      if (valid) begin
        rgb = BG;
        if (hit) begin
          a = (py - m_sy) * 32 + (px - m_sx);
          m_addr = 10'(a);
          if (rom[a][12]) rgb = rom[a][11:0];
        end
      end
      exp_q.push_back({k + 32'd2, rgb, hs, vs});
      commit = (x == 0) && (y == 0);
      ack = commit && req_v;
      evt_q.push_back({k, m_addr, commit, ack});
      if (ack) begin
        m_sx = pos_x_v;
        m_sy = pos_y_v;
      end
    end
  endtask

  task automatic seg(input int y, input int x0, input int len);
    int x;
    for (int i = 0; i < len; i++) begin
      x = (x0 + i) % 800;
      if (x == 0 && y == 0) x = 1;
      drive_cycle(x, y, 1'b0);
    end
  endtask

  task automatic rand_seg();
    int y, x0;
    if ($urandom_range(0, 2) != 0) begin
      y  = (m_sy + V_OFF - 3 + int'($urandom_range(0, 37))) % 525;
      x0 = (m_sx + H_OFF - 8 + int'($urandom_range(0, 20))) % 800;
    end else begin
      y  = int'($urandom_range(0, 524));
      x0 = int'($urandom_range(0, 799));
    end
    seg(y, x0, 48);
  endtask

  task automatic frame(input int nseg, input bit drop);
    drive_cycle(0, 0, 1'b0);
    if (drop) req_v = 0;
    repeat (nseg) rand_seg();
  endtask

  task automatic rom_fill(input bit transparent);
    repeat (3) drive_cycle(5, 5, 1'b0);
    for (int i = 0; i < 1024; i++)
      rom[i] = transparent ? 13'h0FFF : 13'($urandom);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [PW-1:0] pe;
    logic [EW-1:0] ee;
    logic [13:0] pg;
    logic [11:0] eg;
    forever begin
      @(posedge CLK);
      #1;
      while (exp_q.size() > 0 && exp_q[0][PW-1 -: 32] <= cyc) begin
        pe = exp_q.pop_front();
        pg = {R, G, B, H_SYNC, V_SYNC};
        checks++;
        if (pg !== pe[13:0]) begin
          failures++;
          $display("FAIL pixel cyc=%0d got rgb=%h hs=%b vs=%b exp rgb=%h hs=%b vs=%b",
                   cyc, pg[13:2], pg[1], pg[0], pe[13:2], pe[1], pe[0]);
        end
      end
      while (evt_q.size() > 0 && evt_q[0][EW-1 -: 32] <= cyc) begin
        ee = evt_q.pop_front();
        eg = {ROM_ADDR, FRAME_TICK, POS_ACK};
        checks++;
        if (eg !== ee[11:0]) begin
          failures++;
          $display("FAIL event cyc=%0d got addr=%0d tick=%b ack=%b exp addr=%0d tick=%b ack=%b",
                   cyc, eg[11:2], eg[1], eg[0], ee[11:2], ee[1], ee[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1; X = '0; Y = 10'd1; VALID = 0; H_SYNC_IN = 1; V_SYNC_IN = 1;
    POS_X = '0; POS_Y = '0; POS_REQ = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 13'($urandom);

    repeat (4) drive_cycle(300, 100, 1'b1);
    // Background only: sprite hidden after reset.
    frame(8, 0);

    // Commit (100,50) and check addressing / texel colour.
    rom_fill(0);
    rom[0] = 13'h1ABC;
    rom[33] = 13'h1123;
    req_v = 1; pos_x_v = 100; pos_y_v = 50;
    frame(0, 1);
    drive_cycle(242, 82, 1'b0);
    drive_cycle(243, 83, 1'b0);
    repeat (8) rand_seg();

    // Mid-line reset: the next frame must show background only.
    seg(90, 230, 20);
    repeat (3) drive_cycle(250, 90, 1'b1);
    seg(90, 250, 30);
    frame(4, 0);
    seg(90, 236, 40);
    seg(84, 236, 40);

    // Transparent ROM.
    req_v = 1; pos_x_v = 100; pos_y_v = 50;
    rom_fill(1);
    frame(8, 1);

    // Clipping at the lower-right corner.
    rom_fill(0);
    req_v = 1; pos_x_v = 630; pos_y_v = 470;
    frame(6, 1);
    seg(502, 760, 40);
    seg(511, 765, 30);
    seg(512, 765, 30);
    drive_cycle(782, 505, 1'b0);

    // Request raised mid-frame with data changing before the commit.
    frame(2, 0);
    seg(150, 200, 20);
    req_v = 1; pos_x_v = 10; pos_y_v = 10;
    seg(200, 300, 30);
    pos_x_v = 20;
    seg(210, 150, 40);
    frame(6, 0);
    frame(6, 1);
    frame(3, 0);

    // Request pending across a reset.
    req_v = 1; pos_x_v = 300; pos_y_v = 200;
    seg(100, 100, 10);
    repeat (3) drive_cycle(120, 100, 1'b1);
    seg(100, 123, 10);
    frame(8, 1);

    // Random positions and textures.
    repeat (6) begin
      rom_fill(0);
      req_v = 1;
      pos_x_v = int'($urandom_range(0, 700));
      pos_y_v = int'($urandom_range(0, 520));
      frame(8, 1);
    end

    repeat (4) drive_cycle(5, 5, 1'b0);
    for (int i = 0; i < 20 && (exp_q.size() > 0 || evt_q.size() > 0); i++) begin
      @(posedge CLK);
      #2;
    end
    if (exp_q.size() > 0 || evt_q.size() > 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp pending=0", exp_q.size() + evt_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
